// File: rtl/net_tx_arbiter.sv
// Frame-aware 2:1 arbiter sharing the MAC transmit stream between the ARP and UDP/IP sources.
// ARP has streak-bounded priority; a stall watchdog releases a grant whose source stops mid-frame.
module net_tx_arbiter #(
    parameter int unsigned MAX_ARP_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             logic_clk,
    input  logic             logic_rst,
    input  logic [7:0]       arp_tdata_in,
    input  logic             arp_tvalid_in,
    output logic             arp_tready_out,
    input  logic             arp_tlast_in,
    input  logic [7:0]       net_rtrans_data_in,
    input  logic             net_rtrans_valid_in,
    output logic             net_rtrans_ready_out,
    input  logic             net_rtrans_last_in,
    output logic [7:0]       net_tmac_data_out,
    output logic             net_tmac_valid_out,
    input  logic             net_tmac_ready_in,
    output logic             net_tmac_last_out,
    output logic             frame_abort_out,
    output logic [CNT_W-1:0] arp_frame_cnt_out,
    output logic [CNT_W-1:0] trans_frame_cnt_out
);

    localparam int unsigned STREAK_W = $clog2(MAX_ARP_STREAK + 1);
    localparam int unsigned WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam int unsigned WD_LIM   = (TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_ARP_STREAK);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(WD_LIM);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_GNT_ARP   = 2'd1;
    localparam logic [1:0] ST_GNT_TRANS = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [STREAK_W-1:0] streak;
    logic [WD_W-1:0]     wd;
    logic [CNT_W-1:0]    arp_cnt;
    logic [CNT_W-1:0]    trans_cnt;
    logic                hs;
    logic                arp_done;
    logic                trans_done;

    // State register
    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision and grant-muxed data path
    always_comb begin
        state_nxt            = state;
        net_tmac_data_out    = 8'd0;
        net_tmac_valid_out   = 1'b0;
        net_tmac_last_out    = 1'b0;
        arp_tready_out       = 1'b0;
        net_rtrans_ready_out = 1'b0;
        hs                   = 1'b0;
        arp_done             = 1'b0;
        trans_done           = 1'b0;
        frame_abort_out      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (arp_tvalid_in && ((streak < STREAK_MAX) || !net_rtrans_valid_in)) begin
                    state_nxt = ST_GNT_ARP;
                end else if (net_rtrans_valid_in) begin
                    state_nxt = ST_GNT_TRANS;
                end
            end
            ST_GNT_ARP: begin
                net_tmac_data_out  = arp_tdata_in;
                net_tmac_valid_out = arp_tvalid_in;
                net_tmac_last_out  = arp_tlast_in;
                arp_tready_out     = net_tmac_ready_in;
            end
            ST_GNT_TRANS: begin
                net_tmac_data_out    = net_rtrans_data_in;
                net_tmac_valid_out   = net_rtrans_valid_in;
                net_tmac_last_out    = net_rtrans_last_in;
                net_rtrans_ready_out = net_tmac_ready_in;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        hs         = net_tmac_valid_out && net_tmac_ready_in;
        arp_done   = hs && net_tmac_last_out && (state == ST_GNT_ARP);
        trans_done = hs && net_tmac_last_out && (state == ST_GNT_TRANS);

        // A handshake in the timeout cycle takes precedence over the forced release
        frame_abort_out = WD_EN && (state != ST_IDLE) && !hs && (wd == WD_LAST);

        if (hs && net_tmac_last_out) begin
            state_nxt = ST_IDLE;
        end else if (frame_abort_out) begin
            state_nxt = ST_IDLE;
        end
    end

    // Watchdog, streak and frame counters
    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            wd        <= '0;
            streak    <= '0;
            arp_cnt   <= '0;
            trans_cnt <= '0;
        end else begin
            if (!WD_EN || (state == ST_IDLE) || hs || frame_abort_out) begin
                wd <= '0;
            end else begin
                wd <= wd + WD_W'(1);
            end

            if (arp_done) begin
                arp_cnt <= arp_cnt + CNT_W'(1);
                if (streak != STREAK_MAX) begin
                    streak <= streak + STREAK_W'(1);
                end
            end

            if (trans_done) begin
                trans_cnt <= trans_cnt + CNT_W'(1);
                streak    <= '0;
            end
        end
    end

    assign arp_frame_cnt_out   = arp_cnt;
    assign trans_frame_cnt_out = trans_cnt;

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Scoreboard bench for net_tx_arbiter: a frame-level reference model predicts the output beat order;
// a monitor pops and compares every MAC handshake independently of the stimulus thread.
module tb_net_tx_arbiter;

    localparam int unsigned MAX_STREAK = 4;
    localparam int unsigned TIMEOUT    = 16;
    localparam int unsigned CNT_W      = 16;

    logic             clk = 1'b0;
    logic             logic_rst;
    logic [7:0]       arp_tdata_in;
    logic             arp_tvalid_in;
    logic             arp_tready_out;
    logic             arp_tlast_in;
    logic [7:0]       net_rtrans_data_in;
    logic             net_rtrans_valid_in;
    logic             net_rtrans_ready_out;
    logic             net_rtrans_last_in;
    logic [7:0]       net_tmac_data_out;
    logic             net_tmac_valid_out;
    logic             net_tmac_ready_in;
    logic             net_tmac_last_out;
    logic             frame_abort_out;
    logic [CNT_W-1:0] arp_frame_cnt_out;
    logic [CNT_W-1:0] trans_frame_cnt_out;

    always #5 clk = ~clk;

    net_tx_arbiter #(
        .MAX_ARP_STREAK (MAX_STREAK),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .logic_clk            (clk),
        .logic_rst            (logic_rst),
        .arp_tdata_in         (arp_tdata_in),
        .arp_tvalid_in        (arp_tvalid_in),
        .arp_tready_out       (arp_tready_out),
        .arp_tlast_in         (arp_tlast_in),
        .net_rtrans_data_in   (net_rtrans_data_in),
        .net_rtrans_valid_in  (net_rtrans_valid_in),
        .net_rtrans_ready_out (net_rtrans_ready_out),
        .net_rtrans_last_in   (net_rtrans_last_in),
        .net_tmac_data_out    (net_tmac_data_out),
        .net_tmac_valid_out   (net_tmac_valid_out),
        .net_tmac_ready_in    (net_tmac_ready_in),
        .net_tmac_last_out    (net_tmac_last_out),
        .frame_abort_out      (frame_abort_out),
        .arp_frame_cnt_out    (arp_frame_cnt_out),
        .trans_frame_cnt_out  (trans_frame_cnt_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Source-side byte queues {last, data}, popped by the driver on handshake
    logic [8:0] arp_q[$];
    logic [8:0] trans_q[$];
    int         arp_limit = 32'h3fff_ffff;
    int         arp_sent = 0;
    bit         rand_ready = 1'b0;
    int         zero_run = 0;

    // Reference model: pending frames per source, streak, completed-frame counts
    logic [8:0] m_arp_bytes[$];
    logic [8:0] m_trans_bytes[$];
    int         m_arp_lens[$];
    int         m_trans_lens[$];
    int         m_streak = 0;
    int         m_arp_cnt = 0;
    int         m_trans_cnt = 0;

    // Scoreboard entries {src (1 = trans), last, data}
    logic [9:0] exp_q[$];
    int         beats_seen = 0;
    int         last_hs_cyc = 0;
    int         abort_cnt = 0;
    bit         bubble_chk = 1'b0;
    bit         abort_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic add_frame(input bit src, input int len);
        logic [8:0] b;
        for (int i = 0; i < len; i++) begin
            b = {1'(i == len - 1), 8'($urandom)};
            if (src) begin
                trans_q.push_back(b);
                m_trans_bytes.push_back(b);
            end else begin
                arp_q.push_back(b);
                m_arp_bytes.push_back(b);
            end
        end
        if (src) m_trans_lens.push_back(len);
        else     m_arp_lens.push_back(len);
    endtask

    task automatic emit(input bit src);
        int n;
        if (src) begin
            n = m_trans_lens.pop_front();
            repeat (n) exp_q.push_back({1'b1, m_trans_bytes.pop_front()});
            m_trans_cnt++;
            m_streak = 0;
        end else begin
            n = m_arp_lens.pop_front();
            repeat (n) exp_q.push_back({1'b0, m_arp_bytes.pop_front()});
            m_arp_cnt++;
            if (m_streak < int'(MAX_STREAK)) m_streak++;
        end
    endtask

    // Order all pending frames by the priority/streak rule
    task automatic resolve();
        while (m_arp_lens.size() > 0 || m_trans_lens.size() > 0) begin
            if (m_arp_lens.size() > 0 && (m_streak < int'(MAX_STREAK) || m_trans_lens.size() == 0))
                emit(1'b0);
            else
                emit(1'b1);
        end
    endtask

    task automatic drive_inputs();
        arp_tvalid_in = (arp_q.size() > 0) && (arp_sent < arp_limit);
        {arp_tlast_in, arp_tdata_in} = (arp_q.size() > 0) ? arp_q[0] : 9'd0;
        net_rtrans_valid_in = (trans_q.size() > 0);
        {net_rtrans_last_in, net_rtrans_data_in} = (trans_q.size() > 0) ? trans_q[0] : 9'd0;
        if (!rand_ready || zero_run >= 4 || $urandom_range(1, 0) == 1) begin
            net_tmac_ready_in = 1'b1;
            zero_run = 0;
        end else begin
            net_tmac_ready_in = 1'b0;
            zero_run++;
        end
    endtask

    // Source/MAC driver: handshakes sampled at negedge, next beat presented just after posedge
    initial begin
        bit hs_a;
        bit hs_t;
        drive_inputs();
        forever begin
            @(negedge clk);
            hs_a = arp_tvalid_in && arp_tready_out;
            hs_t = net_rtrans_valid_in && net_rtrans_ready_out;
            @(posedge clk);
            #1;
            if (hs_a && arp_q.size() > 0) begin
                void'(arp_q.pop_front());
                arp_sent++;
            end
            if (hs_t && trans_q.size() > 0) void'(trans_q.pop_front());
            drive_inputs();
        end
    end

    // Monitor: compares every MAC handshake against the scoreboard
    always @(negedge clk) begin
        logic [9:0] e;
        if (logic_rst) begin
            bubble_chk = 1'b0;
            abort_chk  = 1'b0;
        end else begin
            if (bubble_chk) check("bubble_after_last", 32'(net_tmac_valid_out), 32'd0);
            bubble_chk = 1'b0;
            if (abort_chk) begin
                check("idle_after_abort",
                      32'({net_tmac_valid_out, arp_tready_out, net_rtrans_ready_out}), 32'd0);
                abort_chk = 1'b0;
            end
            if (net_tmac_valid_out && net_tmac_ready_in) begin
                last_hs_cyc = cyc;
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'({net_tmac_last_out, net_tmac_data_out}), 32'h3ff);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_last_data", 32'({net_tmac_last_out, net_tmac_data_out}), 32'(e[8:0]));
                    check("beat_readies", 32'({arp_tready_out, net_rtrans_ready_out}),
                          e[9] ? 32'd1 : 32'd2);
                end
                if (net_tmac_last_out) bubble_chk = 1'b1;
            end
            if (frame_abort_out) begin
                abort_cnt++;
                check("abort_delay", 32'(cyc - last_hs_cyc), 32'(TIMEOUT));
                abort_chk = 1'b1;
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_beats(input string name, input int target, input int budget);
        int n = 0;
        while (beats_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(beats_seen >= target), 32'd1);
    endtask

    task automatic check_counts(input string name);
        repeat (2) @(negedge clk);
        check({name, "_arp_cnt"}, 32'(arp_frame_cnt_out), 32'(m_arp_cnt));
        check({name, "_trans_cnt"}, 32'(trans_frame_cnt_out), 32'(m_trans_cnt));
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({net_tmac_data_out, net_tmac_valid_out, net_tmac_last_out, arp_tready_out,
                         net_rtrans_ready_out, frame_abort_out}), 32'd0);
        check({name, "_cnts"}, {arp_frame_cnt_out, trans_frame_cnt_out}, 32'd0);
    endtask

    initial begin
        int c0;
        int n;
        int base;

        // Reset state
        logic_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk);
        #2 logic_rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        // Single 42-byte ARP frame: 1 decision cycle + 42 beats
        add_frame(1'b0, 42);
        resolve();
        n = 0;
        while (!arp_tvalid_in && n < 10) begin @(negedge clk); n++; end
        c0 = cyc;
        n = 0;
        while (arp_frame_cnt_out != CNT_W'(1) && n < 200) begin @(negedge clk); n++; end
        check("arp_single_latency", 32'(cyc - c0), 32'd43);
        wait_drain("arp_single_drain", 200);
        check_counts("arp_single");

        // Both sources queued: ARP streak bounded, then trans wins
        for (int i = 0; i < 6; i++) add_frame(1'b0, 42);
        for (int i = 0; i < 2; i++) add_frame(1'b1, 60);
        resolve();
        wait_drain("streak_drain", 2000);
        check_counts("streak");

        // ARP arrives while a trans frame is mid-flight
        base = beats_seen;
        add_frame(1'b1, 60);
        resolve();
        wait_beats("midframe_beats", base + 20, 200);
        add_frame(1'b0, 42);
        resolve();
        wait_drain("midframe_drain", 500);
        check_counts("midframe");

        // 100 random frames under 50% MAC backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 100; i++) add_frame(1'($urandom), int'($urandom_range(64, 1)));
        resolve();
        wait_drain("random_drain", 30000);
        rand_ready = 1'b0;
        check_counts("random");

        // Reset during beat 20 of a trans frame
        base = beats_seen;
        add_frame(1'b1, 60);
        resolve();
        wait_beats("rst_beats", base + 20, 200);
        @(posedge clk);
        #2;
        logic_rst = 1'b1;
        arp_q.delete();
        trans_q.delete();
        exp_q.delete();
        m_arp_bytes.delete();
        m_trans_bytes.delete();
        m_arp_lens.delete();
        m_trans_lens.delete();
        m_streak = 0;
        m_arp_cnt = 0;
        m_trans_cnt = 0;
        repeat (2) @(negedge clk);
        check_all_zero("midframe_reset");
        @(posedge clk);
        #2 logic_rst = 1'b0;
        add_frame(1'b0, 42);
        resolve();
        wait_drain("after_reset_drain", 200);
        check_counts("after_reset");

        // ARP stalls after 10 bytes: watchdog releases, pending trans goes next
        base = beats_seen;
        arp_limit = arp_sent + 10;
        add_frame(1'b0, 42);
        for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, m_arp_bytes.pop_front()});
        m_arp_lens[0] = m_arp_lens[0] - 10;
        wait_beats("abort_first_beats", base + 10, 100);
        add_frame(1'b1, 20);
        emit(1'b1);
        n = 0;
        while (abort_cnt == 0 && n < 100) begin @(negedge clk); n++; end
        check("abort_seen", 32'(abort_cnt), 32'd1);
        check("abort_arp_cnt_held", 32'(arp_frame_cnt_out), 32'(m_arp_cnt));
        repeat (3) @(posedge clk);
        arp_limit = 32'h3fff_ffff;
        resolve();
        wait_drain("abort_drain", 500);
        check_counts("abort");
        check("abort_total", 32'(abort_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
